// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: instruction width, nop, reset PC and fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  // Instruction addresses are word aligned; low two bits are always dropped.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single outstanding request, variable-latency response.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall/squash, plus the one-entry buffer used while decode stalls.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_deliver,
  input  logic            i_from_buf,
  input  logic            i_buf_load,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_buf;
  ifid_t           r_ifid;
  logic            r_valid;
  logic [XLEN-1:0] w_instr_in;

  assign w_instr_in = i_from_buf ? r_buf : i_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= NOP_INSTR;
    end else if (i_buf_load) begin
      r_buf <= i_rdata;
    end
  end

  // Without a delivery the slot becomes a bubble; PC+4 is kept for debug visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid.instr    <= NOP_INSTR;
      r_ifid.pc_plus4 <= '0;
      r_valid         <= 1'b0;
    end else if (i_stall) begin
      r_ifid  <= r_ifid;
      r_valid <= r_valid;
    end else if (i_deliver) begin
      r_ifid.instr    <= w_instr_in;
      r_ifid.pc_plus4 <= i_pc_plus4;
      r_valid         <= 1'b1;
    end else begin
      r_ifid.instr <= NOP_INSTR;
      r_valid      <= 1'b0;
    end
  end

  assign o_instr    = r_ifid.instr;
  assign o_pc_plus4 = r_ifid.pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one-outstanding imem reads and feeds the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchWait
);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;
  logic            w_req;
  logic            w_deliver;
  logic            w_from_buf;
  logic            w_buf_load;

  // A stalled decode stage cannot act on its branch outcome yet.
  assign w_redirect = PCSrcD & ~StallD;
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_target   = pc_align(PCBranchD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ISSUE;
      r_pc    <= pc_align(RESET_PC);
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_deliver   = 1'b0;
    w_from_buf  = 1'b0;
    w_buf_load  = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (!StallF) begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_ISSUE;
          end else if (!StallD) begin
            w_deliver   = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_ISSUE;
        end else if (!StallD) begin
          w_deliver   = 1'b1;
          w_from_buf  = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // The stale response still has to be absorbed before a new request may go out.
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end
        if (imem.imem_rvalid) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_ISSUE;
      end
    endcase
  end

  assign imem.imem_req  = w_req & ~reset;
  assign imem.imem_addr = r_pc;
  assign FetchWait      = (r_state != ST_HOLD) & ~w_deliver;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (StallD),
    .i_deliver  (w_deliver),
    .i_from_buf (w_from_buf),
    .i_buf_load (w_buf_load),
    .i_rdata    (imem.imem_rdata),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (InstrD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

endmodule
